ralu: RTL and testbench

RALU -- requirements
Module: RALU

---
 rtl/ralu.sv | 94 +++++++++
 tb/tb_ralu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ralu.sv
// rtl/ralu.sv - register-file ALU with X/Y operand registers, shiftable Y and gated result
module ralu (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] DataIn,
    input  logic [3:0] S,
    input  logic       M,
    input  logic       Pin,
    input  logic       A,
    input  logic [3:0] v,
    input  logic       wr,
    input  logic [2:0] adr,
    input  logic       ISR,
    input  logic       ISL,
    output logic       OSR,
    output logic       OSL,
    output logic       Pout,
    output logic [3:0] R
);

    logic [3:0] rf [8];
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] bus;
    logic [3:0] f;
    logic [3:0] k;
    logic [4:0] sum;
    logic       carry;

    // Bus reads the pre-edge register contents, so a same-edge write never forwards
    assign bus = A ? DataIn : rf[adr];

    // ALU: per-bit truth-table lookup in logic mode, X + K + Pin in arithmetic mode
    always_comb begin
        k     = 4'b0000;
        f     = 4'b0000;
        carry = 1'b0;
        unique case (S[1:0])
            2'b00: k = 4'b0000;
            2'b01: k = y;
            2'b10: k = ~y;
            2'b11: k = 4'b1111;
        endcase
        sum = {1'b0, x} + {1'b0, k} + {4'b0000, Pin};
        if (M) begin
            f     = sum[3:0];
            carry = sum[4];
        end else begin
            for (int i = 0; i < 4; i++) begin
                f[i] = S[{x[i], y[i]}];
            end
        end
    end

    assign Pout = carry;
    assign R    = v[3] ? f : 4'b0000;
    assign OSR  = y[0];
    assign OSL  = y[3];

    // Operand register X: load from bus or hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x <= 4'b0000;
        end else if (v[0]) begin
            x <= bus;
        end
    end

    // Operand register Y: hold, shift right, shift left or load from bus
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            y <= 4'b0000;
        end else begin
            unique case (v[2:1])
                2'b00: y <= y;
                2'b01: y <= {ISR, y[3:1]};
                2'b10: y <= {y[2:0], ISL};
                2'b11: y <= bus;
            endcase
        end
    end

    // Register file write: external data when A=1, otherwise the result from the old X/Y
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= 4'b0000;
            end
        end else if (wr) begin
            rf[adr] <= A ? DataIn : f;
        end
    end

endmodule

// File: tb/tb_ralu.sv
// tb/tb_ralu.sv - scoreboard bench for ralu
module tb_ralu;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] DataIn;
    logic [3:0] S;
    logic       M;
    logic       Pin;
    logic       A;
    logic [3:0] v;
    logic       wr;
    logic [2:0] adr;
    logic       ISR;
    logic       ISL;
    logic       OSR;
    logic       OSL;
    logic       Pout;
    logic [3:0] R;

    ralu dut (
        .clock  (clock),
        .reset  (reset),
        .DataIn (DataIn),
        .S      (S),
        .M      (M),
        .Pin    (Pin),
        .A      (A),
        .v      (v),
        .wr     (wr),
        .adr    (adr),
        .ISR    (ISR),
        .ISL    (ISL),
        .OSR    (OSR),
        .OSL    (OSL),
        .Pout   (Pout),
        .R      (R)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];
    string      tag_q [$];

    logic [3:0] mx;
    logic [3:0] my;
    logic [3:0] mrf [8];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU: returns {carry, result}
    function automatic logic [4:0] model_alu(input logic [3:0] xv, input logic [3:0] yv,
                                             input logic [3:0] s, input logic m, input logic pin);
        logic [3:0] res;
        int         kk;
        int         total;
        res = 4'b0000;
        if (!m) begin
            for (int i = 0; i < 4; i++) begin
                case ({xv[i], yv[i]})
                    2'b00: res[i] = s[0];
                    2'b01: res[i] = s[1];
                    2'b10: res[i] = s[2];
                    default: res[i] = s[3];
                endcase
            end
            return {1'b0, res};
        end
        case (s[1:0])
            2'b00:   kk = 0;
            2'b01:   kk = int'(yv);
            2'b10:   kk = 15 - int'(yv);
            default: kk = 15;
        endcase
        total = int'(xv) + kk + int'(pin);
        res   = 4'(total % 16);
        return {(total > 15), res};
    endfunction

    task automatic model_clear();
        mx = 4'b0000;
        my = 4'b0000;
        for (int i = 0; i < 8; i++) mrf[i] = 4'b0000;
    endtask

    task automatic step(input string tag, input logic [3:0] din, input logic [3:0] s,
                        input logic m, input logic pin, input logic a, input logic [3:0] vv,
                        input logic w, input logic [2:0] ad, input logic isr, input logic isl);
        logic [4:0] pf;
        logic [3:0] mbus;
        logic [7:0] exp;
        string      t;
        @(negedge clock);
        DataIn = din; S = s; M = m; Pin = pin; A = a; v = vv; wr = w; adr = ad;
        ISR = isr; ISL = isl;
        pf   = model_alu(mx, my, s, m, pin);
        mbus = a ? din : mrf[ad];
        exp  = {1'b0, my[3], my[0], pf[4], (vv[3] ? pf[3:0] : 4'b0000)};
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #2;
        t = tag_q.pop_front();
        check(t, {1'b0, OSL, OSR, Pout, R}, exp_q.pop_front());
        if (w) mrf[ad] = a ? din : pf[3:0];
        if (vv[0]) mx = mbus;
        case (vv[2:1])
            2'b01:   my = {isr, my[3:1]};
            2'b10:   my = {my[2:0], isl};
            2'b11:   my = mbus;
            default: my = my;
        endcase
    endtask

    // Load X from RF[i] and show it on R through the F = X truth table
    task automatic readback_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            step({tag, "_ld"}, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'(i), 1'b0, 1'b0);
            step({tag, "_rd"}, 4'h0, 4'b1100, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 3'(i), 1'b0, 1'b0);
            check({tag, "_zero"}, {4'h0, R}, 8'h00);
        end
    endtask

    initial begin
        reset = 1'b1;
        DataIn = 4'hF; S = 4'b1100; M = 1'b0; Pin = 1'b1; A = 1'b1; v = 4'b1111;
        wr = 1'b1; adr = 3'd0; ISR = 1'b1; ISL = 1'b1;
        model_clear();

        // Edges under reset with every load/write requested must change nothing
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        v = 4'b1000; S = 4'b1100; #1;
        check("rst_x", {4'h0, R}, 8'h00);
        S = 4'b1010; #1;
        check("rst_y", {4'h0, R}, 8'h00);
        S = 4'b0000; Pin = 1'b0; #1;
        check("rst_outs", {1'b0, OSL, OSR, Pout, R}, 8'h00);
        wr = 1'b0; v = 4'b0000; A = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        readback_all("rst_rf");

        // Fill the register file from DataIn
        step("fill0", 4'd6, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 3'd0, 1'b0, 1'b0);
        step("fill1", 4'd3, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 3'd1, 1'b0, 1'b0);
        step("fill2", 4'd2, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 3'd2, 1'b0, 1'b0);
        step("fill3", 4'd2, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 3'd3, 1'b0, 1'b0);
        step("ldx6", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 3'd0, 1'b0, 1'b0);
        step("ldy2", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b0, 3'd2, 1'b0, 1'b0);

        // 6 + 2 + 1 written back to RF[0]
        step("add62", 4'h0, 4'b1001, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, 3'd0, 1'b0, 1'b0);
        check("add62_r", {3'b0, Pout, R}, 8'h09);
        step("rf0_ld", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0);
        step("rf0_rd", 4'h0, 4'b1100, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
        check("rf0_is9", {4'h0, R}, 8'h09);

        // 3 + 2 + 1 written back to RF[1]
        step("ldx3", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b0, 1'b0);
        step("ldy2b", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 3'd3, 1'b0, 1'b0);
        step("add32", 4'h0, 4'b1001, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, 3'd1, 1'b0, 1'b0);
        check("add32_r", {3'b0, Pout, R}, 8'h06);
        step("rf1_ld", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd1, 1'b0, 1'b0);
        step("rf1_rd", 4'h0, 4'b1100, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd1, 1'b0, 1'b0);
        check("rf1_is6", {4'h0, R}, 8'h06);

        // Carry-out and wrap cases
        step("ldxF", 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0);
        step("ldy1", 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 3'd0, 1'b0, 1'b0);
        step("wrap", 4'h0, 4'b1101, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
        check("wrap_r", {3'b0, Pout, R}, 8'h10);
        step("ldx5", 4'h5, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0);
        step("ldy3", 4'h3, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 3'd0, 1'b0, 1'b0);
        step("sub", 4'h0, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
        check("sub_r", {3'b0, Pout, R}, 8'h12);
        step("kones", 4'h0, 4'b0111, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
        check("kones_r", {3'b0, Pout, R}, 8'h14);

        // Y shifting and serial outputs
        step("ldyA", 4'hA, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 3'd0, 1'b0, 1'b0);
        step("shr", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 3'd0, 1'b1, 1'b0);
        step("shr_y", 4'h0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
        check("shr_val", {2'b0, OSL, OSR, R}, 8'h3D);
        step("shl", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 3'd0, 1'b0, 1'b0);
        step("shl_y", 4'h0, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
        check("shl_val", {2'b0, OSL, OSR, R}, 8'h2A);

        // Logic mode on X=1100, Y=1010
        step("ldxC", 4'hC, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0);
        step("and", 4'h0, 4'b1000, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
        check("and_r", {3'b0, Pout, R}, 8'h08);
        step("xor", 4'h0, 4'b0110, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
        check("xor_r", {3'b0, Pout, R}, 8'h06);
        step("gated", 4'h0, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
        check("gated_r", {4'h0, R}, 8'h00);

        // Same-edge write of F with X/Y loading from the address being written
        step("same_edge", 4'h0, 4'b1001, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 3'd2, 1'b0, 1'b0);
        step("same_edge_xy", 4'h0, 4'b1100, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd2, 1'b0, 1'b0);
        check("same_edge_old", {4'h0, R}, 8'h02);
        step("same_edge_ld", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 3'd2, 1'b0, 1'b0);
        step("same_edge_rd", 4'h0, 4'b1100, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 3'd2, 1'b0, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 60; n++) begin
            step("rand", 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset mid-sequence
        step("pre_x", 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b1, 3'd5, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        M = 1'b0; S = 4'b1100; v = 4'b1000; wr = 1'b0; #1;
        check("async_x", {4'h0, R}, 8'h00);
        S = 4'b1010; #1;
        check("async_y", {2'b0, OSL, OSR, R}, 8'h00);
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        readback_all("mid_rf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
